mem_port_arbiter: RTL and testbench

- Shares one single-port data memory between two requesters: port 0 is the CPU load/store side (Mem_WrAddr/Mem_WrData/ReadData path), port 1 is the program-loader/debug port.
- Round-robin arbitration; one transaction outstanding at a time.
- Registered downstream request; read-response routing back to the owner; read timeout with error reporting.
- Sits between the CPU core top level and the data memory.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/rr_pick2.sv | 15 +
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the data-memory port arbiter: FSM encoding, port ids
// and the data word returned on a timed-out read.
package riscv_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT_RD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = IDLE,
    S_ISSUE   = ISSUE,
    S_WAIT_RD = WAIT_RD
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: a lone requester wins, and on a tie
// the port that did not own the previous transaction wins.
module rr_pick2
  import riscv_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       valid,
  output logic       winner
);

  assign valid  = |req;
  assign winner = (&req) ? ~last_owner : req[PORT_DBG];

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU port (0)
// and the loader/debug port (1); read timeout with error. ARB_PERF_CNT_EN adds counters.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            TIMEOUT  = 16,
  parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEFAULT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy,
`ifdef ARB_PERF_CNT_EN
  output logic          err,
  output logic [31:0]   gnt_cnt0,
  output logic [31:0]   gnt_cnt1,
  output logic [15:0]   timeout_cnt
`else
  output logic          err
`endif
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  arb_state_t    r_state, w_next_state;
  logic          w_pick_valid, w_pick_winner;
  logic          r_last_owner, r_owner;
  logic          r_mem_req, r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [7:0]    r_cnt;
  logic [1:0]    r_rvalid;
  logic [DW-1:0] r_rdata0, r_rdata1;
  logic          r_err;
  logic          w_ack, w_rsp, w_tmo, w_done;
  logic [DW-1:0] w_rsp_data;

  rr_pick2 u_pick (
    .req       ({m1_req, m0_req}),
    .last_owner(r_last_owner),
    .valid     (w_pick_valid),
    .winner    (w_pick_winner)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_ack        = 1'b0;
    w_rsp        = 1'b0;
    w_tmo        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_valid) w_next_state = S_ISSUE;
      end
      S_ISSUE: begin
        w_ack = mem_ack;
        if (mem_ack) w_next_state = r_mem_we ? S_IDLE : S_WAIT_RD;
      end
      S_WAIT_RD: begin
        // mem_rvalid is only honoured here; a response on the last counted cycle still wins
        w_rsp = mem_rvalid;
        w_tmo = !mem_rvalid && (r_cnt == CNT_LAST);
        if (w_rsp || w_tmo) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_done     = w_rsp | w_tmo;
  assign w_rsp_data = w_rsp ? mem_rdata : ERR_DATA;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_owner <= PORT_DBG;
      r_owner      <= PORT_CPU;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cnt        <= '0;
    end else begin
      if (r_state == S_IDLE && w_pick_valid) begin
        r_owner      <= w_pick_winner;
        r_last_owner <= w_pick_winner;
        r_mem_req    <= 1'b1;
        r_mem_we     <= w_pick_winner ? m1_we    : m0_we;
        r_mem_addr   <= w_pick_winner ? m1_addr  : m0_addr;
        r_mem_wdata  <= w_pick_winner ? m1_wdata : m0_wdata;
      end
      if (w_ack) r_mem_req <= 1'b0;
      if (r_state == S_WAIT_RD) r_cnt <= r_cnt + 8'd1;
      else                      r_cnt <= '0;
    end
  end

  // Response data is zero outside its pulse so the idle port never shows stale data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rvalid <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid[0] <= w_done && (r_owner == PORT_CPU);
      r_rvalid[1] <= w_done && (r_owner == PORT_DBG);
      r_rdata0    <= (w_done && r_owner == PORT_CPU) ? w_rsp_data : '0;
      r_rdata1    <= (w_done && r_owner == PORT_DBG) ? w_rsp_data : '0;
      r_err       <= w_tmo;
    end
  end

  assign m0_gnt    = w_ack && (r_owner == PORT_CPU);
  assign m1_gnt    = w_ack && (r_owner == PORT_DBG);
  assign m0_rvalid = r_rvalid[0];
  assign m1_rvalid = r_rvalid[1];
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign owner     = r_owner;
  assign busy      = (r_state != S_IDLE);
  assign err       = r_err;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_gnt_cnt0, r_gnt_cnt1;
  logic [15:0] r_timeout_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gnt_cnt0    <= '0;
      r_gnt_cnt1    <= '0;
      r_timeout_cnt <= '0;
    end else begin
      if (m0_gnt) r_gnt_cnt0 <= r_gnt_cnt0 + 32'd1;
      if (m1_gnt) r_gnt_cnt1 <= r_gnt_cnt1 + 32'd1;
      if (w_tmo && r_timeout_cnt != 16'hFFFF) r_timeout_cnt <= r_timeout_cnt + 16'd1;
    end
  end

  assign gnt_cnt0    = r_gnt_cnt0;
  assign gnt_cnt1    = r_gnt_cnt1;
  assign timeout_cnt = r_timeout_cnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] ERRW    = 32'hDEAD_BEEF;

  logic        clk = 1'b0, reset = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m0_gnt, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        owner, busy, err;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] gnt_cnt0, gnt_cnt1;
  logic [15:0] timeout_cnt;
`endif

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TIMEOUT), .ERR_DATA(ERRW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy),
`ifdef ARB_PERF_CNT_EN
    .err(err), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .timeout_cnt(timeout_cnt)
`else
    .err(err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  // Transaction-level reference: one transaction in flight, described by who owns it,
  // whether memory has taken it, and how many cycles a read has waited for data.
  int          md_port;
  bit          md_we, md_acked;
  logic [31:0] md_addr, md_wdata;
  int          md_age, md_last;
  bit          ex_owner, ex_err;
  bit   [1:0]  ex_rv;
  logic [31:0] ex_rd [2];
  int          ex_gc0, ex_gc1, ex_tc;
  bit          issuing, eg0, eg1;

  task automatic model_reset();
    md_port = -1; md_we = 0; md_acked = 0; md_addr = '0; md_wdata = '0;
    md_age = 0; md_last = 1; ex_owner = 0; ex_err = 0; ex_rv = '0;
    ex_rd[0] = '0; ex_rd[1] = '0; ex_gc0 = 0; ex_gc1 = 0; ex_tc = 0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    if (!reset) begin
      model_reset();
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_mem_req", mem_req, 1'b0);
      chk1("rst_owner", owner, 1'b0);
      chk1("rst_gnt", m0_gnt | m1_gnt, 1'b0);
      chk1("rst_rvalid", m0_rvalid | m1_rvalid, 1'b0);
      chk1("rst_err", err, 1'b0);
`ifdef ARB_PERF_CNT_EN
      chk("rst_gnt_cnt0", gnt_cnt0, 32'd0);
      chk("rst_gnt_cnt1", gnt_cnt1, 32'd0);
`endif
    end else begin
      issuing = (md_port >= 0) && !md_acked;
      eg0 = issuing && mem_ack && (md_port == 0);
      eg1 = issuing && mem_ack && (md_port == 1);
      chk1("m_busy", busy, md_port >= 0);
      chk1("m_mem_req", mem_req, issuing);
      if (issuing) begin
        chk1("m_mem_we", mem_we, md_we);
        chk("m_mem_addr", mem_addr, md_addr);
        if (md_we) chk("m_mem_wdata", mem_wdata, md_wdata);
      end
      chk1("m_owner", owner, ex_owner);
      chk1("m_gnt0", m0_gnt, eg0);
      chk1("m_gnt1", m1_gnt, eg1);
      chk1("m_rvalid0", m0_rvalid, ex_rv[0]);
      chk1("m_rvalid1", m1_rvalid, ex_rv[1]);
      if (ex_rv[0]) chk("m_rdata0", m0_rdata, ex_rd[0]);
      if (ex_rv[1]) chk("m_rdata1", m1_rdata, ex_rd[1]);
      chk1("m_err", err, ex_err);
`ifdef ARB_PERF_CNT_EN
      chk("m_gnt_cnt0", gnt_cnt0, 32'(ex_gc0));
      chk("m_gnt_cnt1", gnt_cnt1, 32'(ex_gc1));
      chk("m_timeout_cnt", 32'(timeout_cnt), 32'(ex_tc));
`endif
      ex_rv  = '0;
      ex_err = 0;
      if (eg0) ex_gc0++;
      if (eg1) ex_gc1++;
      if (md_port < 0) begin
        if (m0_req || m1_req) begin
          md_port  = (m0_req && m1_req) ? 1 - md_last : (m0_req ? 0 : 1);
          md_last  = md_port;
          ex_owner = (md_port == 1);
          md_acked = 0;
          md_we    = (md_port == 1) ? m1_we    : m0_we;
          md_addr  = (md_port == 1) ? m1_addr  : m0_addr;
          md_wdata = (md_port == 1) ? m1_wdata : m0_wdata;
        end
      end else if (!md_acked) begin
        if (mem_ack) begin
          if (md_we) md_port = -1;
          else begin md_acked = 1; md_age = 0; end
        end
      end else begin
        md_age++;
        if (mem_rvalid) begin
          ex_rv[md_port] = 1; ex_rd[md_port] = mem_rdata; md_port = -1;
        end else if (md_age == TIMEOUT) begin
          ex_rv[md_port] = 1; ex_rd[md_port] = ERRW; ex_err = 1; md_port = -1;
          if (ex_tc < 16'hFFFF) ex_tc++;
        end
      end
    end
  end

  task automatic idle_inputs();
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    mem_ack = 0; mem_rvalid = 0;
  endtask

  task automatic do_reset();
    to_drive(); reset = 0; idle_inputs();
    to_drive();
    to_drive(); reset = 1;
  endtask

  task automatic drain(input string name);
    to_drive(); m0_req = 0; m1_req = 0; mem_rvalid = 0; mem_ack = mem_req;
    for (int c = 0; c < 60; c++) begin
      to_sample();
      if (!busy) break;
      to_drive(); mem_ack = mem_req;
    end
    chk1(name, busy, 1'b0);
    to_drive(); idle_inputs();
  endtask

  task automatic do_write(input bit p, input logic [31:0] a);
    to_drive();
    if (p) begin m1_req = 1; m1_we = 1; m1_addr = a; m1_wdata = ~a; end
    else   begin m0_req = 1; m0_we = 1; m0_addr = a; m0_wdata = ~a; end
    to_drive(); mem_ack = 1;
    to_drive(); mem_ack = 0; m0_req = 0; m1_req = 0;
  endtask

  task automatic random_phase(input int ncyc);
    bit h0, h1, g0, g1, acc, accwe;
    int rd_cnt;
    h0 = 0; h1 = 0; g0 = 0; g1 = 0; acc = 0; accwe = 0; rd_cnt = -1;
    for (int c = 0; c < ncyc; c++) begin
      to_drive();
      if (g0) begin h0 = 0; m0_req = 0; end
      if (g1) begin h1 = 0; m1_req = 0; end
      if (!h0 && $urandom_range(0, 2) == 0) begin
        h0 = 1; m0_req = 1; m0_we = 1'($urandom_range(0, 1));
        m0_addr = $urandom; m0_wdata = $urandom;
      end
      if (!h1 && $urandom_range(0, 2) == 0) begin
        h1 = 1; m1_req = 1; m1_we = 1'($urandom_range(0, 1));
        m1_addr = $urandom; m1_wdata = $urandom;
      end
      mem_rvalid = 0;
      mem_rdata  = $urandom;
      if (acc && !accwe) rd_cnt = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, 20));
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin mem_rvalid = 1; rd_cnt = -1; end
      end else if (mem_req && $urandom_range(0, 7) == 0) begin
        mem_rvalid = 1;
      end
      mem_ack = mem_req && ($urandom_range(0, 2) != 0);
      to_sample();
      g0 = m0_gnt; g1 = m1_gnt;
      acc = mem_req && mem_ack; accwe = mem_we;
    end
  endtask

  bit seq [4];
  int nseq;
  bit pa, early;

  initial begin
    reset = 0;
    to_drive();
    to_drive(); reset = 1;

    // single write from port 0, acked on the second ISSUE cycle
    to_drive(); m0_req = 1; m0_we = 1; m0_addr = 32'h100; m0_wdata = 32'h1234_5678;
    to_sample(); chk1("wr_busy_c0", busy, 1'b0);
    to_drive();
    to_sample();
    chk1("wr_mem_req", mem_req, 1'b1);
    chk("wr_mem_addr", mem_addr, 32'h100);
    chk1("wr_mem_we", mem_we, 1'b1);
    chk1("wr_gnt_early", m0_gnt, 1'b0);
    to_drive(); mem_ack = 1;
    to_sample();
    chk1("wr_gnt0", m0_gnt, 1'b1);
    chk1("wr_gnt1", m1_gnt, 1'b0);
    chk("wr_mem_wdata", mem_wdata, 32'h1234_5678);
    to_drive(); mem_ack = 0; m0_req = 0;
    to_sample();
    chk1("wr_busy_done", busy, 1'b0);
    chk1("wr_mem_req_done", mem_req, 1'b0);
    chk1("wr_no_rvalid", m0_rvalid, 1'b0);

    // single read from port 1, data three cycles after ack
    to_drive(); m1_req = 1; m1_we = 0; m1_addr = 32'h40;
    to_drive(); mem_ack = 1;
    to_sample();
    chk1("rd_gnt1", m1_gnt, 1'b1);
    chk1("rd_gnt0", m0_gnt, 1'b0);
    chk("rd_mem_addr", mem_addr, 32'h40);
    chk1("rd_owner", owner, 1'b1);
    to_drive(); mem_ack = 0; m1_req = 0;
    to_drive();
    to_drive(); mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    to_sample(); chk1("rd_rvalid_early", m1_rvalid, 1'b0);
    to_drive(); mem_rvalid = 0;
    to_sample();
    chk1("rd_rvalid1", m1_rvalid, 1'b1);
    chk("rd_rdata1", m1_rdata, 32'hCAFE_F00D);
    chk1("rd_rvalid0", m0_rvalid, 1'b0);
    chk("rd_rdata0", m0_rdata, 32'h0);
    chk1("rd_err", err, 1'b0);

    // contention: both ports read continuously, immediate ack, data one cycle later
    do_reset();
    to_drive();
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    m1_req = 1; m1_we = 0; m1_addr = 32'h20;
    pa = 0; nseq = 0;
    for (int c = 0; c < 40 && nseq < 4; c++) begin
      to_drive(); mem_rvalid = pa; mem_rdata = 32'(c); mem_ack = mem_req;
      to_sample();
      pa = mem_req && mem_ack && !mem_we;
      if (m0_gnt && nseq < 4) begin seq[nseq] = 0; nseq++; end
      if (m1_gnt && nseq < 4) begin seq[nseq] = 1; nseq++; end
    end
    chk("cont_grant_count", 32'(nseq), 32'd4);
    for (int k = 0; k < 4; k++) chk1($sformatf("cont_owner_%0d", k), seq[k], 1'(k % 2));
    drain("cont_drain");

    // read timeout on port 0
    to_drive(); m0_req = 1; m0_we = 0; m0_addr = 32'h200;
    to_drive(); mem_ack = 1;
    to_sample(); chk1("tmo_gnt0", m0_gnt, 1'b1);
    to_drive(); mem_ack = 0; m0_req = 0;
    to_sample();
    chk1("tmo_busy", busy, 1'b1);
    early = 0;
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      to_drive();
      to_sample();
      early |= err | m0_rvalid;
    end
    chk1("tmo_no_early", early, 1'b0);
    to_drive();
    to_sample();
    chk1("tmo_rvalid0", m0_rvalid, 1'b1);
    chk("tmo_rdata0", m0_rdata, 32'hDEAD_BEEF);
    chk1("tmo_err", err, 1'b1);
    chk1("tmo_rvalid1", m1_rvalid, 1'b0);
    to_drive();
    to_sample();
    chk1("tmo_err_pulse", err, 1'b0);
    chk1("tmo_idle", busy, 1'b0);

    // asynchronous reset while port 0 waits for read data
    to_drive(); m0_req = 1; m0_we = 0; m0_addr = 32'h300;
    to_drive(); mem_ack = 1;
    to_drive(); mem_ack = 0; m0_req = 0;
    to_drive();
    to_sample(); chk1("rstrd_busy_before", busy, 1'b1);
    to_drive(); #2; reset = 0; #1;
    chk1("rstrd_busy", busy, 1'b0);
    chk("rstrd_mem_addr", mem_addr, 32'h0);
    chk1("rstrd_owner", owner, 1'b0);
    chk1("rstrd_err", err, 1'b0);
    to_drive();
    to_drive(); reset = 1;
    to_drive(); m1_req = 1; m1_we = 0; m1_addr = 32'h80;
    to_drive(); mem_ack = 1;
    to_sample();
    chk1("rstrd_gnt1", m1_gnt, 1'b1);
    chk1("rstrd_owner1", owner, 1'b1);
    to_drive(); mem_ack = 0; m1_req = 0;
    to_drive(); mem_rvalid = 1; mem_rdata = 32'h55;
    to_sample(); chk1("rstrd_no_stale0", m0_rvalid, 1'b0);
    to_drive(); mem_rvalid = 0;
    to_sample();
    chk1("rstrd_rvalid1", m1_rvalid, 1'b1);
    chk("rstrd_rdata1", m1_rdata, 32'h55);
    chk1("rstrd_rvalid0", m0_rvalid, 1'b0);

`ifdef ARB_PERF_CNT_EN
    do_reset();
    to_sample();
    chk("perf_rst0", gnt_cnt0, 32'd0);
    do_write(0, 32'h1); do_write(1, 32'h2); do_write(0, 32'h3);
    do_write(1, 32'h4); do_write(0, 32'h5);
    to_sample();
    chk("perf_cnt0", gnt_cnt0, 32'd3);
    chk("perf_cnt1", gnt_cnt1, 32'd2);
    do_reset();
    to_sample();
    chk("perf_after_rst0", gnt_cnt0, 32'd0);
    chk("perf_after_rst1", gnt_cnt1, 32'd0);
`endif

    do_reset();
    random_phase(3000);
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
